monopix_ro_sched: RTL and testbench

//  Synthesizable readout scheduler for the 4 MONOPIX front-end flavours
//  (0=PMOS_NOSF, 1=PMOS, 2=COMP, 3=HV), placed in the FPGA/periphery next to the chip pads.

---
 rtl/monopix_ro_pkg.sv | 54 +++++
 rtl/ro_gray_dec.sv | 24 ++
 rtl/monopix_ro_sched.sv | 218 +++++++++++++++++++++
 tb/tb_monopix_ro_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/monopix_ro_pkg.sv
// -----------------------------------------------------------------------------
// monopix_ro_pkg
// Shared types and helpers for the MONOPIX readout scheduler:
//   - t_hit      : 27-bit serial hit word {col, row, le, te}, MSB first on the pad
//   - t_flav     : front-end flavour index (2 bits)
//   - t_ro_state : scheduler FSM states
//   - rr_pick()  : round-robin picker over the per-flavour request vector
// -----------------------------------------------------------------------------
package monopix_ro_pkg;

  localparam int N_FLAV = 4;
  localparam int HIT_W  = 27;

  typedef struct packed {
    logic [5:0] col;
    logic [8:0] row;
    logic [5:0] le;
    logic [5:0] te;
  } t_hit;

  typedef enum logic [1:0] {
    FLAV_PMOS_NOSF = 2'd0,
    FLAV_PMOS      = 2'd1,
    FLAV_COMP      = 2'd2,
    FLAV_HV        = 2'd3
  } t_flav;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_DLY   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_OUT   = 3'd5
  } t_ro_state;

  // Returns the first set request bit at or after ptr, wrapping 3->0.
  // Scanning from the farthest offset down lets the nearest one win.
  // With req == 0 the result is ptr; callers only use it when req != 0.
  function automatic logic [1:0] rr_pick(input logic [N_FLAV-1:0] req,
                                         input logic [1:0]        ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int i = N_FLAV - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        rr_pick = idx;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

endpackage

// File: rtl/ro_gray_dec.sv
// -----------------------------------------------------------------------------
// ro_gray_dec
// 6-bit Gray-to-binary converter, purely combinational.
// Ports:
//   gray_i  in  6  Gray-coded value
//   bin_o   out 6  binary value
// -----------------------------------------------------------------------------
module ro_gray_dec (
  input  logic [5:0] gray_i,
  output logic [5:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    logic [5:0] b;
    b    = 6'd0;
    b[5] = gray_i[5];
    for (int i = 4; i >= 0; i--) begin
      b[i] = b[i+1] ^ gray_i[i];
    end
    bin_o = b;
  end

endmodule

// File: rtl/monopix_ro_sched.sv
// -----------------------------------------------------------------------------
// monopix_ro_sched
// Readout scheduler for the four MONOPIX front-end flavours. Round-robin
// arbitrates pending tokens, drives FREEZE/READ to the granted flavour,
// deserialises its 27-bit hit word (MSB first) and emits it tagged with the
// flavour on a valid/ready stream.
//
// Ports:
//   clk_bx_i      in   1   BX clock, all logic on posedge
//   reset_i       in   1   asynchronous, active-high reset
//   en_flav_i     in   4   per-flavour enable (disabled tokens ignored)
//   token_i       in   4   TOKEN pad level per flavour
//   data_in_i     in   4   serial data pad per flavour
//   freeze_o      out  4   FREEZE pads, one-hot or zero
//   read_o        out  4   READ pads, one-hot or zero
//   hit_data_o    out  29  {flav[1:0], t_hit}
//   hit_valid_o   out  1   hit_data_o valid
//   hit_ready_i   in   1   consumer ready; transfer on valid & ready
//   busy_o        out  1   FSM not idle
//   hit_cnt_o     out  16  accepted hits, saturating
//
// Configuration macro:
//   MONOPIX_RO_GRAY_DECODE_EN  when defined, le/te are Gray->binary decoded
//                              before the output load; otherwise raw Gray
//                              codes are forwarded.
// -----------------------------------------------------------------------------
module monopix_ro_sched
  import monopix_ro_pkg::*;
#(
  parameter int TOKEN_WAIT_CYC = 2,
  parameter int READ_CYC       = 2,
  parameter int DATA_DLY       = 3
) (
  input  logic               clk_bx_i,
  input  logic               reset_i,
  input  logic [N_FLAV-1:0]  en_flav_i,
  input  logic [N_FLAV-1:0]  token_i,
  input  logic [N_FLAV-1:0]  data_in_i,
  output logic [N_FLAV-1:0]  freeze_o,
  output logic [N_FLAV-1:0]  read_o,
  output logic [HIT_W+1:0]   hit_data_o,
  output logic               hit_valid_o,
  input  logic               hit_ready_i,
  output logic               busy_o,
  output logic [15:0]        hit_cnt_o
);

  t_ro_state          state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  t_flav              gnt_q, gnt_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [HIT_W-1:0]   sr_q, sr_d;
  logic [N_FLAV-1:0]  freeze_q, freeze_d;
  logic [N_FLAV-1:0]  read_q, read_d;
  logic [HIT_W+1:0]   hit_data_q, hit_data_d;
  logic               hit_valid_q, hit_valid_d;
  logic [15:0]        hit_cnt_q, hit_cnt_d;

  logic [N_FLAV-1:0]  req_s;
  t_hit               raw_s;
  t_hit               hit_word_s;

  assign req_s = token_i & en_flav_i;
  assign raw_s = sr_q;

`ifdef MONOPIX_RO_GRAY_DECODE_EN
  logic [5:0] le_bin_s;
  logic [5:0] te_bin_s;

  ro_gray_dec u_le_dec (
    .gray_i (raw_s.le),
    .bin_o  (le_bin_s)
  );

  ro_gray_dec u_te_dec (
    .gray_i (raw_s.te),
    .bin_o  (te_bin_s)
  );

  assign hit_word_s = {raw_s.col, raw_s.row, le_bin_s, te_bin_s};
`else
  assign hit_word_s = raw_s;
`endif

  // FSM next state, shift register, output slot and hit counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 5'd1;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    sr_d        = sr_q;
    hit_data_d  = hit_data_q;
    hit_valid_d = hit_valid_q;
    hit_cnt_d   = hit_cnt_q;

    // Stream transfer: drop valid and count the accepted hit.
    if (hit_valid_q && hit_ready_i) begin
      hit_valid_d = 1'b0;
      if (hit_cnt_q != 16'hFFFF) begin
        hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        hit_cnt_d = hit_cnt_q;
      end
    end else begin
      hit_valid_d = hit_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = 5'd0;
        // A full output slot blocks new grants; tokens stay pending on chip,
        // so an OUT load can never collide with a transfer.
        if ((req_s != 4'b0000) && !hit_valid_q) begin
          gnt_d   = t_flav'(rr_pick(req_s, rr_ptr_q));
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 5'(TOKEN_WAIT_CYC - 1)) begin
          state_d = ST_READ;
          cnt_d   = 5'd0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_READ: begin
        if (cnt_q == 5'(READ_CYC - 1)) begin
          state_d = ST_DLY;
          cnt_d   = 5'd0;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DLY: begin
        if (cnt_q == 5'(DATA_DLY - 1)) begin
          state_d = ST_SHIFT;
          cnt_d   = 5'd0;
        end else begin
          state_d = ST_DLY;
        end
      end
      ST_SHIFT: begin
        sr_d = {sr_q[HIT_W-2:0], data_in_i[gnt_q]};
        if (cnt_q == 5'(HIT_W - 1)) begin
          state_d = ST_OUT;
          cnt_d   = 5'd0;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_OUT: begin
        hit_data_d  = {gnt_q, hit_word_s};
        hit_valid_d = 1'b1;
        // The flavour just served becomes lowest priority.
        rr_ptr_d    = gnt_q + 2'd1;
        state_d     = ST_IDLE;
        cnt_d       = 5'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Pad drives follow the next state so they line up with the state register.
  always_comb begin
    freeze_d = 4'b0000;
    read_d   = 4'b0000;
    if ((state_d == ST_WAIT) || (state_d == ST_READ)) begin
      freeze_d = 4'b0001 << gnt_d;
    end else begin
      freeze_d = 4'b0000;
    end
    if (state_d == ST_READ) begin
      read_d = 4'b0001 << gnt_d;
    end else begin
      read_d = 4'b0000;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_bx_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      gnt_q       <= FLAV_PMOS_NOSF;
      rr_ptr_q    <= 2'd0;
      sr_q        <= 27'd0;
      freeze_q    <= 4'b0000;
      read_q      <= 4'b0000;
      hit_data_q  <= 29'd0;
      hit_valid_q <= 1'b0;
      hit_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      sr_q        <= sr_d;
      freeze_q    <= freeze_d;
      read_q      <= read_d;
      hit_data_q  <= hit_data_d;
      hit_valid_q <= hit_valid_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  assign freeze_o    = freeze_q;
  assign read_o      = read_q;
  assign hit_data_o  = hit_data_q;
  assign hit_valid_o = hit_valid_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_monopix_ro_sched.sv
// -----------------------------------------------------------------------------
// tb_monopix_ro_sched
// Directed bench for monopix_ro_sched. A small chip model serialises a
// per-flavour hit word MSB first, starting 3 cycles after READ falls.
// -----------------------------------------------------------------------------
module tb_monopix_ro_sched;

  logic        clk_bx   = 1'b0;
  logic        reset    = 1'b1;
  logic [3:0]  en_flav  = 4'b0000;
  logic [3:0]  token    = 4'b0000;
  logic [3:0]  data_in  = 4'b0000;
  logic        hit_ready = 1'b0;
  logic [3:0]  freeze;
  logic [3:0]  read;
  logic [28:0] hit_data;
  logic        hit_valid;
  logic        busy;
  logic [15:0] hit_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [26:0] ser_word [4];
  logic        ser_act   = 1'b0;
  int          ser_cnt   = 0;
  logic [1:0]  ser_flav  = 2'd0;
  logic [3:0]  read_prev = 4'b0000;

  monopix_ro_sched dut (
    .clk_bx_i    (clk_bx),
    .reset_i     (reset),
    .en_flav_i   (en_flav),
    .token_i     (token),
    .data_in_i   (data_in),
    .freeze_o    (freeze),
    .read_o      (read),
    .hit_data_o  (hit_data),
    .hit_valid_o (hit_valid),
    .hit_ready_i (hit_ready),
    .busy_o      (busy),
    .hit_cnt_o   (hit_cnt)
  );

  always #5 clk_bx = ~clk_bx;

  // Chip model: after READ falls, 3 idle cycles, then 27 bits MSB first.
  always @(posedge clk_bx) begin
    #1;
    if (reset) begin
      ser_act = 1'b0;
      data_in = 4'b0000;
    end else begin
      if (ser_act) begin
        ser_cnt = ser_cnt + 1;
        if (ser_cnt >= 3 && ser_cnt <= 29) begin
          data_in = 4'b0000;
          data_in[ser_flav] = ser_word[ser_flav][29 - ser_cnt];
        end else if (ser_cnt > 29) begin
          ser_act = 1'b0;
          data_in = 4'b0000;
        end
      end
      if ((read_prev & ~read) != 4'b0000) begin
        ser_act = 1'b1;
        ser_cnt = 0;
        for (int f = 0; f < 4; f++) begin
          if (read_prev[f] && !read[f]) ser_flav = 2'(f);
        end
      end
    end
    read_prev = read;
  end

  function automatic logic [5:0] g2b(input logic [5:0] g);
    logic [5:0] b;
    for (int i = 0; i < 6; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [28:0] exp_hit(input logic [1:0] f, input logic [26:0] w);
    logic [5:0] le;
    logic [5:0] te;
    le = w[11:6];
    te = w[5:0];
`ifdef MONOPIX_RO_GRAY_DECODE_EN
    le = g2b(le);
    te = g2b(te);
`endif
    return {f, w[26:12], le, te};
  endfunction

  function automatic logic [26:0] mk_word(input logic [5:0] col, input logic [8:0] row,
                                          input logic [5:0] le, input logic [5:0] te);
    return {col, row, le, te};
  endfunction

  task automatic tick();
    @(posedge clk_bx);
    #1;
  endtask

  task automatic apply_reset();
    token = 4'b0000;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Ticks until freeze is nonzero; n = ticks taken (max+1 on timeout).
  task automatic wait_freeze(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (freeze == 4'b0000 && n <= max);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!hit_valid && n <= max);
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_vec++;
    if ({freeze, read, hit_valid, busy} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got freeze=%b read=%b valid=%b busy=%b, want all 0", freeze, read, hit_valid, busy);
    end
    n_vec++;
    if (hit_data !== 29'd0 || hit_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_data: got hit_data=%h hit_cnt=%0d, want 0/0", hit_data, hit_cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n, frz_n, rd_n, lat;
    logic [26:0] w;
    w = mk_word(6'd3, 9'd100, 6'h05, 6'h0A);
    ser_word[0] = w;
    en_flav = 4'hF;
    hit_ready = 1'b1;
    token = 4'b0001;
    wait_freeze(10, n);
    token = 4'b0000;
    n_vec++;
    if (n !== 1 || freeze !== 4'b0001) begin
      n_err++;
      $display("FAIL single_grant: got %0d cycles freeze=%b, want 1 cycle freeze=0001", n, freeze);
    end
    frz_n = 1; rd_n = 0; lat = 0;
    do begin
      tick();
      lat++;
      if (freeze[0]) frz_n++;
      if (read[0]) rd_n++;
    end while (!hit_valid && lat < 80);
    n_vec++;
    if (lat !== 35) begin
      n_err++;
      $display("FAIL single_latency: got %0d, want 35", lat);
    end
    n_vec++;
    if (frz_n !== 4 || rd_n !== 2) begin
      n_err++;
      $display("FAIL single_pulses: got freeze %0d read %0d cycles, want 4 and 2", frz_n, rd_n);
    end
    n_vec++;
    if (hit_data !== exp_hit(2'd0, w)) begin
      n_err++;
      $display("FAIL single_data: got %h, want %h", hit_data, exp_hit(2'd0, w));
    end
    tick();
    n_vec++;
    if (hit_valid !== 1'b0 || hit_cnt !== 16'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_accept: got valid=%b cnt=%0d busy=%b, want 0/1/0", hit_valid, hit_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    logic stray;
    ser_word[0] = mk_word(6'd9, 9'd9, 6'd9, 6'd9);
    en_flav = 4'hF;
    hit_ready = 1'b1;
    token = 4'b0001;
    wait_freeze(10, n);
    token = 4'b0000;
    n = 0;
    while (read == 4'b0000 && n < 10) begin tick(); n++; end
    while (read != 4'b0000 && n < 20) begin tick(); n++; end
    for (int i = 0; i < 23; i++) tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_shift_busy: got busy=%b before reset, want 1", busy);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (freeze !== 4'b0000 || read !== 4'b0000 || hit_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_shift_async: got freeze=%b read=%b valid=%b busy=%b, want 0", freeze, read, hit_valid, busy);
    end
    tick();
    reset = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy || hit_valid) stray = 1'b1;
    end
    n_vec++;
    if (stray !== 1'b0 || hit_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rst_shift_idle: got activity=%b cnt=%0d, want 0/0", stray, hit_cnt);
    end
  endtask

  task automatic test_round_robin();
    int k, hits;
    logic twohot;
    logic [3:0] prev, one, exp_f;
    apply_reset();
    for (int f = 0; f < 4; f++) ser_word[f] = mk_word(6'(f + 1), 9'(40 * f + 7), 6'(f), 6'(63 - f));
    en_flav = 4'hF;
    hit_ready = 1'b1;
    token = 4'hF;
    k = 0; hits = 0; twohot = 1'b0; prev = 4'b0000; one = 4'b0001;
    for (int c = 0; c < 300 && hits < 5; c++) begin
      tick();
      if ($countones(freeze) > 1) twohot = 1'b1;
      if (freeze != 4'b0000 && prev == 4'b0000) begin
        exp_f = one << k[1:0];
        n_vec++;
        if (freeze !== exp_f) begin
          n_err++;
          $display("FAIL rr_grant%0d: got freeze=%b, want %b", k, freeze, exp_f);
        end
        k++;
      end
      prev = freeze;
      if (hit_valid) begin
        n_vec++;
        if (hit_data !== exp_hit(hits[1:0], ser_word[hits[1:0]])) begin
          n_err++;
          $display("FAIL rr_hit%0d: got %h, want %h", hits, hit_data, exp_hit(hits[1:0], ser_word[hits[1:0]]));
        end
        hits++;
      end
    end
    token = 4'b0000;
    n_vec++;
    if (hits !== 5 || twohot !== 1'b0) begin
      n_err++;
      $display("FAIL rr_summary: got hits=%0d twohot=%b, want 5/0", hits, twohot);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_backpressure();
    int n;
    logic bad_frz, bad_hold;
    logic [28:0] hd;
    apply_reset();
    ser_word[0] = mk_word(6'd12, 9'd345, 6'd17, 6'd44);
    ser_word[2] = mk_word(6'd50, 9'd2, 6'd33, 6'd1);
    en_flav = 4'hF;
    hit_ready = 1'b0;
    token = 4'b0001;
    wait_freeze(10, n);
    token = 4'b0000;
    wait_valid(60, n);
    hd = hit_data;
    n_vec++;
    if (hd !== exp_hit(2'd0, ser_word[0])) begin
      n_err++;
      $display("FAIL bp_first: got %h, want %h", hd, exp_hit(2'd0, ser_word[0]));
    end
    token = 4'b0100;
    bad_frz = 1'b0; bad_hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (freeze != 4'b0000) bad_frz = 1'b1;
      if (hit_data !== hd || hit_valid !== 1'b1) bad_hold = 1'b1;
    end
    n_vec++;
    if (bad_frz !== 1'b0 || bad_hold !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stall: got grant=%b unstable=%b, want 0/0", bad_frz, bad_hold);
    end
    hit_ready = 1'b1;
    tick();
    n_vec++;
    if (hit_valid !== 1'b0 || hit_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL bp_release: got valid=%b cnt=%0d, want 0/1", hit_valid, hit_cnt);
    end
    wait_freeze(10, n);
    token = 4'b0000;
    n_vec++;
    if (freeze !== 4'b0100) begin
      n_err++;
      $display("FAIL bp_grant2: got freeze=%b, want 0100", freeze);
    end
    wait_valid(60, n);
    n_vec++;
    if (hit_data !== exp_hit(2'd2, ser_word[2])) begin
      n_err++;
      $display("FAIL bp_hit2: got %h, want %h", hit_data, exp_hit(2'd2, ser_word[2]));
    end
    tick();
    n_vec++;
    if (hit_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL bp_count: got %0d, want 2", hit_cnt);
    end
  endtask

  task automatic test_disabled();
    logic act;
    apply_reset();
    en_flav = 4'b1110;
    token = 4'b0001;
    act = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (freeze != 4'b0000 || read != 4'b0000 || busy) act = 1'b1;
    end
    token = 4'b0000;
    n_vec++;
    if (act !== 1'b0) begin
      n_err++;
      $display("FAIL disabled: got pad/busy activity=%b, want 0", act);
    end
  endtask

  task automatic test_gray();
    int n;
    logic [5:0] exp_le;
`ifdef MONOPIX_RO_GRAY_DECODE_EN
    exp_le = 6'd63;
`else
    exp_le = 6'b100000;
`endif
    apply_reset();
    ser_word[3] = mk_word(6'd7, 9'd300, 6'b100000, 6'd0);
    en_flav = 4'hF;
    hit_ready = 1'b1;
    token = 4'b1000;
    wait_freeze(10, n);
    token = 4'b0000;
    wait_valid(60, n);
    n_vec++;
    if (hit_data[11:6] !== exp_le || hit_data[28:27] !== 2'd3) begin
      n_err++;
      $display("FAIL gray_le: got le=%b flav=%0d, want le=%b flav=3", hit_data[11:6], hit_data[28:27], exp_le);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_shift();
    test_round_robin();
    test_backpressure();
    test_disabled();
    test_gray();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
